trng_sampler: RTL and testbench

- Entropy harvester sitting directly downstream of the free-running LUT ring oscillator.
- Synchronises the asynchronous oscillator bit into the system clock and samples it at a programmable rate.
- Removes bias with a von Neumann corrector and packs the corrected bits into WIDTH-bit words.
- Delivers the words on a valid/ready interface to the consumer.

---
 rtl/trng_sampler.sv | 190 +++++++++++++++++++
 tb/tb_trng_sampler.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_sampler.sv
// Ring-oscillator entropy harvester: synchroniser, sample divider, von Neumann corrector, word packer.
// Optional repetition-count health test is compiled in with `define TRNG_HEALTH_EN.
module trng_sampler #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_DIV  = 4,
    parameter int REP_LIMIT   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             raw_i,
    input  logic             enable,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    input  logic             rready,
    output logic [7:0]       drop_cnt,
    output logic             health_fail
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        HAVE_FIRST
    } pair_state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DIV_W-1:0]       div_q, div_d;
    pair_state_e            state_q, state_d;
    logic                   first_q, first_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-2:0]       shift_q, shift_d;
    logic [WIDTH-1:0]       rdata_q, rdata_d;
    logic                   rvalid_q, rvalid_d;
    logic [7:0]             drop_q, drop_d;

    logic             s_raw;
    logic             strobe;
    logic             emit;
    logic             word_done;
    logic [WIDTH-1:0] word;
    logic             slot_free;

    assign s_raw  = sync_q[SYNC_STAGES-1];
    assign strobe = enable && (div_q == DIV_LAST);
    // The newest emitted bit enters at the LSB, so the first bit of a word ends at the MSB.
    assign word   = {shift_q, first_q};

`ifdef TRNG_HEALTH_EN
    localparam int REP_W = $clog2(REP_LIMIT + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_LIMIT);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             last_q, last_d;
    logic             hf_q, hf_d;

    always_comb begin
        rep_d  = rep_q;
        last_d = last_q;
        hf_d   = hf_q;
        if (!enable) begin
            rep_d = '0;
        end else if (strobe) begin
            last_d = s_raw;
            if (rep_q == '0 || s_raw != last_q) begin
                rep_d = REP_W'(1);
            end else if (rep_q != REP_MAX) begin
                rep_d = rep_q + 1'b1;
            end
            if (rep_d == REP_MAX) begin
                hf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q  <= '0;
            last_q <= 1'b0;
            hf_q   <= 1'b0;
        end else begin
            rep_q  <= rep_d;
            last_q <= last_d;
            hf_q   <= hf_d;
        end
    end

    assign health_fail = hf_q;
`else
    assign health_fail = 1'b0;
`endif

    assign rvalid    = rvalid_q && !health_fail;
    assign rdata     = rdata_q;
    assign drop_cnt  = drop_q;
    assign slot_free = !rvalid || rready;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
        div_d   = '0;
        state_d = state_q;
        first_d = first_q;
        emit    = 1'b0;
        if (enable) begin
            div_d = strobe ? '0 : div_q + 1'b1;
        end
        if (!enable) begin
            state_d = IDLE;
        end else if (strobe) begin
            case (state_q)
                IDLE: begin
                    first_d = s_raw;
                    state_d = HAVE_FIRST;
                end
                HAVE_FIRST: begin
                    // Unequal pair yields the first sample; equal pairs carry bias and are dropped.
                    emit    = (s_raw != first_q);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;
        if (!enable) begin
            cnt_d = '0;
        end else if (emit) begin
            shift_d = word[WIDTH-2:0];
            if (cnt_q == CNT_LAST) begin
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        drop_d   = drop_q;
        if (health_fail) begin
            rvalid_d = 1'b0;
        end else begin
            if (rvalid && rready) begin
                rvalid_d = 1'b0;
            end
            if (word_done) begin
                if (slot_free) begin
                    rdata_d  = word;
                    rvalid_d = 1'b1;
                end else if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            div_q    <= '0;
            state_q  <= IDLE;
            first_q  <= 1'b0;
            cnt_q    <= '0;
            shift_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            drop_q   <= 8'd0;
        end else begin
            sync_q   <= sync_d;
            div_q    <= div_d;
            state_q  <= state_d;
            first_q  <= first_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_trng_sampler.sv
// Bench for trng_sampler: directed scenarios plus randomized runs against a queue-based reference model.
module tb_trng_sampler;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int DIV   = 1;
    localparam int REP   = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             raw_i = 1'b0;
    logic             enable = 1'b0;
    logic             rready = 1'b0;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;
    logic [7:0]       drop_cnt;
    logic             health_fail;

    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    trng_sampler #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .SAMPLE_DIV(DIV), .REP_LIMIT(REP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .raw_i(raw_i), .enable(enable),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .drop_cnt(drop_cnt), .health_fail(health_fail)
    );

    // Reference model: sample stream -> pairs -> corrected bits -> words -> one-slot output.
    logic             m_hist[$];
    logic             m_pair[$];
    logic             m_bits[$];
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_drop;
    int               m_div;
    logic             m_s;
    logic             m_word_rdy;
    logic [WIDTH-1:0] m_w;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_hist = {};
            for (int k = 0; k < SYNC; k++) m_hist.push_back(1'b0);
            m_pair = {};
            m_bits = {};
            m_valid = 1'b0;
            m_data = '0;
            m_drop = 0;
            m_div = 0;
        end else begin
            m_s = m_hist.pop_front();
            m_hist.push_back(raw_i);
            m_word_rdy = 1'b0;
            if (!enable) begin
                m_pair = {};
                m_bits = {};
                m_div = 0;
            end else if (m_div == DIV - 1) begin
                m_div = 0;
                m_pair.push_back(m_s);
                if (m_pair.size() == 2) begin
                    if (m_pair[0] != m_pair[1]) m_bits.push_back(m_pair[0]);
                    m_pair = {};
                end
                if (m_bits.size() == WIDTH) begin
                    for (int k = 0; k < WIDTH; k++) m_w[WIDTH-1-k] = m_bits[k];
                    m_bits = {};
                    m_word_rdy = 1'b1;
                end
            end else begin
                m_div = m_div + 1;
            end
            if (m_word_rdy) begin
                if (!m_valid || rready) begin
                    m_valid = 1'b1;
                    m_data = m_w;
                end else if (m_drop < 255) begin
                    m_drop = m_drop + 1;
                end
            end else if (m_valid && rready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Transfer monitor
    logic [WIDTH-1:0] got[$];
    int               vld_cycles = 0;

    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            vld_cycles = vld_cycles + 1;
            if (rready) got.push_back(rdata);
        end
    end

    logic samp[$];

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        rready = 1'b0;
        raw_i = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic add_pairs(input logic a, input logic b, input int n);
        repeat (n) begin
            samp.push_back(a);
            samp.push_back(b);
        end
    endtask

    // Drives samp so that sample k is the one strobed on the k-th enabled edge.
    task automatic run_samples(input logic rdy_mode, input int rdy_at, input int gap_at);
        int n;
        n = samp.size();
        for (int i = 0; i < n + SYNC; i++) begin
            raw_i  = (i < n) ? samp[i] : 1'b0;
            enable = (i >= SYNC) && (i != gap_at);
            rready = (rdy_at < 0) ? rdy_mode : (i == rdy_at);
            idle(1);
        end
        enable = 1'b0;
        samp = {};
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        enable = 1'b1;
        rready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            raw_i = i[0];
            idle(1);
        end
        if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rdata); end else n_pass++;
        if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end else n_pass++;
        if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end else n_pass++;
        if (health_fail !== 1'b0) begin n_fail++; $display("FAIL reset_health: got %b want 0", health_fail); end else n_pass++;
        rready = 1'b0;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            raw_i = $urandom_range(0, 1);
            idle(1);
            if (rvalid !== 1'b0) bad++;
        end
        if (bad != 0) begin n_fail++; $display("FAIL early_rvalid: got %0d valid cycles want 0", bad); end else n_pass++;
        enable = 1'b0;
    endtask

    task automatic test_packing();
        int g0, v0;
        do_reset();
        g0 = got.size();
        v0 = vld_cycles;
        repeat (4) begin
            add_pairs(1'b1, 1'b0, 1);
            add_pairs(1'b0, 1'b1, 1);
        end
        run_samples(1'b1, -1, -1);
        idle(3);
        if (got.size() != g0 + 1 || got[got.size()-1] !== 8'hAA) begin
            n_fail++; $display("FAIL pack_aa: got %0d words last %h want 1 word AA", got.size() - g0, got[got.size()-1]);
        end else n_pass++;
        if (vld_cycles - v0 != 1) begin n_fail++; $display("FAIL pack_vld_len: got %0d cycles want 1", vld_cycles - v0); end else n_pass++;
        g0 = got.size();
        add_pairs(1'b0, 1'b1, 8);
        run_samples(1'b1, -1, -1);
        idle(3);
        if (got.size() != g0 + 1 || got[got.size()-1] !== 8'h00) begin
            n_fail++; $display("FAIL pack_00: got %0d words last %h want 1 word 00", got.size() - g0, got[got.size()-1]);
        end else n_pass++;
    endtask

    task automatic test_bias();
        int g0, v0;
        do_reset();
        v0 = vld_cycles;
        add_pairs(1'b1, 1'b1, 8);
        add_pairs(1'b0, 1'b0, 8);
        run_samples(1'b1, -1, -1);
        idle(3);
        if (vld_cycles != v0) begin n_fail++; $display("FAIL bias_reject: got %0d valid cycles want 0", vld_cycles - v0); end else n_pass++;
        g0 = got.size();
        add_pairs(1'b1, 1'b0, 8);
        run_samples(1'b1, -1, -1);
        idle(3);
        if (got.size() != g0 + 1 || got[got.size()-1] !== 8'hFF) begin
            n_fail++; $display("FAIL bias_ff: got %0d words last %h want 1 word FF", got.size() - g0, got[got.size()-1]);
        end else n_pass++;
    endtask

    task automatic test_backpressure();
        int g0;
        do_reset();
        g0 = got.size();
        repeat (4) begin
            add_pairs(1'b1, 1'b0, 1);
            add_pairs(1'b0, 1'b1, 1);
        end
        add_pairs(1'b1, 1'b0, 8);
        add_pairs(1'b0, 1'b1, 8);
        run_samples(1'b0, -1, -1);
        idle(2);
        if (rvalid !== 1'b1 || rdata !== 8'hAA) begin
            n_fail++; $display("FAIL bp_hold: got rvalid=%b rdata=%h want 1/AA", rvalid, rdata);
        end else n_pass++;
        if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL bp_drop: got %0d want 2", drop_cnt); end else n_pass++;
        rready = 1'b1;
        idle(1);
        rready = 1'b0;
        if (rvalid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got rvalid=%b want 0", rvalid); end else n_pass++;
        if (got.size() != g0 + 1 || got[got.size()-1] !== 8'hAA) begin
            n_fail++; $display("FAIL bp_xfer: got %0d words want 1 word AA", got.size() - g0);
        end else n_pass++;
        // Pending word is lost on an asynchronous reset.
        add_pairs(1'b1, 1'b0, 8);
        run_samples(1'b0, -1, -1);
        idle(1);
        rst_n = 1'b0;
        #1;
        if (rvalid !== 1'b0 || drop_cnt !== 8'd0 || rdata !== '0) begin
            n_fail++; $display("FAIL async_reset: got rvalid=%b drop=%0d rdata=%h want 0/0/00", rvalid, drop_cnt, rdata);
        end else n_pass++;
        idle(1);
        rst_n = 1'b1;
    endtask

    task automatic test_enable_abort();
        int g0;
        do_reset();
        g0 = got.size();
        add_pairs(1'b0, 1'b1, 5);
        samp.push_back(1'b0);
        add_pairs(1'b1, 1'b0, 8);
        run_samples(1'b1, -1, SYNC + 10);
        idle(3);
        if (got.size() != g0 + 1 || got[got.size()-1] !== 8'hFF) begin
            n_fail++; $display("FAIL abort: got %0d words last %h want 1 word FF", got.size() - g0, got[got.size()-1]);
        end else n_pass++;
    endtask

    task automatic test_simultaneous();
        int g0;
        do_reset();
        g0 = got.size();
        add_pairs(1'b1, 1'b0, 8);
        repeat (4) begin
            add_pairs(1'b1, 1'b0, 1);
            add_pairs(1'b0, 1'b1, 1);
        end
        run_samples(1'b0, SYNC + 31, -1);
        rready = 1'b0;
        if (rvalid !== 1'b1 || rdata !== 8'hAA) begin
            n_fail++; $display("FAIL simul_load: got rvalid=%b rdata=%h want 1/AA", rvalid, rdata);
        end else n_pass++;
        if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL simul_drop: got %0d want 0", drop_cnt); end else n_pass++;
        if (got.size() != g0 + 1 || got[got.size()-1] !== 8'hFF) begin
            n_fail++; $display("FAIL simul_xfer: got %0d words want 1 word FF", got.size() - g0);
        end else n_pass++;
    endtask

    task automatic test_random(input string name, input int cycles, input int en_pct,
                               input int rdy_pct, input bit toggle);
        int shown;
        shown = 0;
        do_reset();
        for (int i = 0; i < cycles; i++) begin
            raw_i  = toggle ? ~raw_i : 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 99) < en_pct);
            rready = ($urandom_range(0, 99) < rdy_pct);
            idle(1);
            if (rvalid !== m_valid || rdata !== m_data || drop_cnt !== 8'(m_drop)) begin
                n_fail++;
                if (shown < 8) begin
                    shown++;
                    $display("FAIL %s cyc %0d: got v=%b d=%h drop=%0d want v=%b d=%h drop=%0d",
                             name, i, rvalid, rdata, drop_cnt, m_valid, m_data, m_drop);
                end
            end else n_pass++;
        end
        enable = 1'b0;
        rready = 1'b0;
    endtask

    task automatic test_saturation();
        test_random("sat_model", 4500, 100, 0, 1'b1);
        if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_sat: got %0d want 255", drop_cnt); end else n_pass++;
    endtask

    task automatic test_health();
        do_reset();
        raw_i = 1'b1;
        rready = 1'b1;
        idle(4);
        enable = 1'b1;
`ifdef TRNG_HEALTH_EN
        idle(REP - 1);
        if (health_fail !== 1'b0) begin n_fail++; $display("FAIL health_early: got %b want 0", health_fail); end else n_pass++;
        idle(1);
        if (health_fail !== 1'b1) begin n_fail++; $display("FAIL health_trip: got %b want 1", health_fail); end else n_pass++;
        raw_i = 1'b0;
        idle(10);
        if (health_fail !== 1'b1 || rvalid !== 1'b0) begin
            n_fail++; $display("FAIL health_sticky: got hf=%b rvalid=%b want 1/0", health_fail, rvalid);
        end else n_pass++;
`else
        idle(REP + 8);
        if (health_fail !== 1'b0) begin n_fail++; $display("FAIL health_tied: got %b want 0", health_fail); end else n_pass++;
`endif
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_packing();
        test_bias();
        test_backpressure();
        test_enable_abort();
        test_simultaneous();
        test_random("rand_model", 3000, 95, 50, 1'b0);
        test_random("rand_slow_rdy", 2000, 97, 10, 1'b0);
        test_saturation();
        test_health();
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
